async_ctrl_gen: RTL and testbench
=================================

// Module: async_ctrl_gen
// PURPOSE
//  Source end of the async-control interface consumed by adff/dffsr-style flops: generates clr (active-high
//  clear), pre (active-high preset) and en (clock enable) for downstream registers. Asserts clear
//  asynchronously on chip reset and releases it synchronously after a hold period. Issues timed software
//  clear/preset pulses and gates enable so downstream flops never see en with clr/pre active.
// PARAMETERS
//  SYNC_STAGES   2  reset-release synchroniser depth (>=2)
//  HOLD_CYCLES   4  cycles clr_o is held after synchronised release (0 allowed)
//  PULSE_CYCLES  2  width of software clr/pre pulses in cycles (>=1; 0 is illegal)
// PORTS
//  clk      in   1  clock, all state on posedge
//  clr      in   1  asynchronous active-low reset
//  sw_clr   in   1  request a clear pulse (sampled only when ready=1)
//  sw_pre   in   1  request a preset pulse (sampled only when ready=1)
//  en_req   in   1  requested downstream enable
//  clr_o    out  1  active-high clear to downstream flops
//  pre_o    out  1  active-high preset to downstream flops
//  en_o     out  1  gated enable to downstream flops
//  ready    out  1  1 = IDLE, requests accepted
// BEHAVIOUR
//  Reset: clr low forces, without waiting for clk: state=RESET, sync chain=0, counter=0,
//   clr_o=1, pre_o=0, en_o=0, ready=0. clr low mid-pulse/mid-hold aborts immediately to these values.
//  States: RESET, HOLD, IDLE, CPULSE, PPULSE; all outputs registered, no comb paths in->out.
//  RESET: sync chain shifts in 1 each edge after clr rises; last stage is 1 after edge SYNC_STAGES.
//   At edge SYNC_STAGES+1 -> HOLD (counter=HOLD_CYCLES), or directly -> IDLE if HOLD_CYCLES=0.
//  HOLD: clr_o=1; counter decrements each edge; leaves to IDLE on the edge it reaches 0.
//   IDLE entered at edge SYNC_STAGES+1+HOLD_CYCLES after clr rises (default: 7th edge).
//  IDLE: clr_o=0, pre_o=0, ready=1. Requests sampled on edge n:
//   sw_clr=1 -> CPULSE: clr_o=1 for PULSE_CYCLES cycles after edge n; IDLE again after edge n+PULSE_CYCLES.
//   sw_pre=1 (sw_clr=0) -> PPULSE: pre_o=1, same timing.
//   sw_clr & sw_pre together -> clear wins; preset request dropped.
//  Requests while ready=0 are ignored, never queued; a held request re-triggers once IDLE is re-entered.
//  en_o: registered, en_o <= en_req when next state is IDLE, else 0. One-cycle latency from en_req.
//   en_o is 0 in the same cycle any pulse starts and during RESET/HOLD.
//  Invariants: clr_o & pre_o never both 1; en_o=1 implies clr_o=0 and pre_o=0; ready=1 iff state=IDLE.
//  Counter width $clog2(max(HOLD_CYCLES,PULSE_CYCLES)+1); no wrap, saturates at 0.
// TESTING
//  1 clr low 3 cycles then high, defaults -> clr_o=1 until 7th posedge, then clr_o=0, ready=1.
//  2 clr low asynchronously between edges while en_o=1 -> clr_o=1, en_o=0, ready=0 before next edge.
//  3 IDLE, en_req=1 one cycle then sw_pre=1 one cycle -> en_o=1 one cycle later; then pre_o=1 for exactly
//    2 cycles, en_o=0 during them, ready=0 during them, ready=1 after.
//  4 IDLE, sw_clr=sw_pre=1 same edge -> clr_o=1 for 2 cycles, pre_o stays 0 throughout.
//  5 sw_clr during CPULSE/HOLD -> ignored, pulse width unchanged; held sw_clr re-triggers at IDLE.
//  6 clr low during PPULSE cycle 1 -> pre_o=0, clr_o=1 at once; HOLD_CYCLES=0 build: ready on 3rd edge.

Source files
------------

// File: rtl/async_ctrl_gen_if.sv
// Control bundle between the async-control source and its consumer/requester.
interface async_ctrl_gen_if;
    logic sw_clr;
    logic sw_pre;
    logic en_req;
    logic clr_o;
    logic pre_o;
    logic en_o;
    logic ready;

    // Requester side: issues clear/preset/enable requests, observes controls.
    modport master (
        output sw_clr,
        output sw_pre,
        output en_req,
        input  clr_o,
        input  pre_o,
        input  en_o,
        input  ready
    );

    // Generator side: accepts requests, drives clr/pre/en to downstream flops.
    modport slave (
        input  sw_clr,
        input  sw_pre,
        input  en_req,
        output clr_o,
        output pre_o,
        output en_o,
        output ready
    );
endinterface

// File: rtl/async_ctrl_gen.sv
// Async-control source: clear asserted asynchronously on reset and released
// synchronously after a hold period, software clear/preset pulses, and an
// enable gated so it is never high while clear or preset is active.
module async_ctrl_gen #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    async_ctrl_gen_if.slave   ctrl
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_HOLD   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_CPULSE = 3'd3,
        ST_PPULSE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_clr_o;
    logic                   r_pre_o;
    logic                   r_en_o;
    logic                   r_ready;
    logic                   w_clr_nxt;
    logic                   w_pre_nxt;
    logic                   w_en_nxt;
    logic                   w_ready_nxt;

    // State, synchroniser, counter and output registers; reset forces clear at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_RESET;
            r_sync  <= '0;
            r_cnt   <= '0;
            r_clr_o <= 1'b1;
            r_pre_o <= 1'b0;
            r_en_o  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= w_sync_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clr_o <= w_clr_nxt;
            r_pre_o <= w_pre_nxt;
            r_en_o  <= w_en_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state/counter decode; outputs are derived from the next state so they register with it.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sync_nxt  = {r_sync[SYNC_STAGES-2:0], 1'b1};

        unique case (r_state)
            ST_RESET: begin
                if (r_sync[SYNC_STAGES-1]) begin
                    if (HOLD_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                        w_cnt_nxt   = CNT_W'(HOLD_CYCLES);
                    end
                end
            end
            ST_HOLD, ST_CPULSE, ST_PPULSE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Clear takes priority when both requests arrive together.
                if (ctrl.sw_clr) begin
                    w_state_nxt = ST_CPULSE;
                    w_cnt_nxt   = CNT_W'(PULSE_CYCLES);
                end else if (ctrl.sw_pre) begin
                    w_state_nxt = ST_PPULSE;
                    w_cnt_nxt   = CNT_W'(PULSE_CYCLES);
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
                w_cnt_nxt   = '0;
            end
        endcase

        w_clr_nxt   = (w_state_nxt == ST_RESET) || (w_state_nxt == ST_HOLD) ||
                      (w_state_nxt == ST_CPULSE);
        w_pre_nxt   = (w_state_nxt == ST_PPULSE);
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_en_nxt    = (w_state_nxt == ST_IDLE) && ctrl.en_req;
    end

    assign ctrl.clr_o = r_clr_o;
    assign ctrl.pre_o = r_pre_o;
    assign ctrl.en_o  = r_en_o;
    assign ctrl.ready = r_ready;

endmodule

// File: tb/tb_async_ctrl_gen.sv
// Directed bench for async_ctrl_gen: default build plus a HOLD_CYCLES=0 build.
module tb_async_ctrl_gen;

    logic clk  = 1'b0;
    logic clr  = 1'b0;
    logic clr0 = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic done    = 1'b0;

    async_ctrl_gen_if if0 ();
    async_ctrl_gen_if if1 ();

    async_ctrl_gen u_dut (
        .clk  (clk),
        .clr  (clr),
        .ctrl (if0)
    );

    async_ctrl_gen #(.HOLD_CYCLES(0)) u_dut0 (
        .clk  (clk),
        .clr  (clr0),
        .ctrl (if1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output invariants on both instances, sampled between edges.
    always @(negedge clk) begin
        if (!done) begin
            check("inv_clr_pre",  32'(if0.clr_o & if0.pre_o), 32'd0);
            check("inv_en_gate",  32'(if0.en_o & (if0.clr_o | if0.pre_o)), 32'd0);
            check("inv0_clr_pre", 32'(if1.clr_o & if1.pre_o), 32'd0);
            check("inv0_en_gate", 32'(if1.en_o & (if1.clr_o | if1.pre_o)), 32'd0);
        end
    end

    initial begin
        if0.sw_clr = 1'b0; if0.sw_pre = 1'b0; if0.en_req = 1'b0;
        if1.sw_clr = 1'b0; if1.sw_pre = 1'b0; if1.en_req = 1'b0;

        // Reset values while clr is held low.
        repeat (3) step();
        check("rst_clr_o", 32'(if0.clr_o), 32'd1);
        check("rst_pre_o", 32'(if0.pre_o), 32'd0);
        check("rst_en_o",  32'(if0.en_o),  32'd0);
        check("rst_ready", 32'(if0.ready), 32'd0);

        // Release: clear held through edge 6, IDLE on edge 7.
        clr = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("rel_clr_o_e%0d", k), 32'(if0.clr_o), (k < 7) ? 32'd1 : 32'd0);
            check($sformatf("rel_ready_e%0d", k), 32'(if0.ready), (k == 7) ? 32'd1 : 32'd0);
        end

        // Enable follows en_req with one cycle latency, then preset pulse with en_req held.
        if0.en_req = 1'b1;
        step();
        check("en_follow", 32'(if0.en_o), 32'd1);
        if0.sw_pre = 1'b1;
        step();
        check("pp1_pre_o", 32'(if0.pre_o), 32'd1);
        check("pp1_en_o",  32'(if0.en_o),  32'd0);
        check("pp1_ready", 32'(if0.ready), 32'd0);
        check("pp1_clr_o", 32'(if0.clr_o), 32'd0);
        if0.sw_pre = 1'b0;
        step();
        check("pp2_pre_o", 32'(if0.pre_o), 32'd1);
        check("pp2_en_o",  32'(if0.en_o),  32'd0);
        check("pp2_ready", 32'(if0.ready), 32'd0);
        step();
        check("pp3_pre_o", 32'(if0.pre_o), 32'd0);
        check("pp3_ready", 32'(if0.ready), 32'd1);
        check("pp3_en_o",  32'(if0.en_o),  32'd1);
        if0.en_req = 1'b0;
        step();
        check("en_drop", 32'(if0.en_o), 32'd0);

        // Simultaneous clear and preset: clear wins.
        if0.sw_clr = 1'b1; if0.sw_pre = 1'b1;
        step();
        check("both1_clr_o", 32'(if0.clr_o), 32'd1);
        check("both1_pre_o", 32'(if0.pre_o), 32'd0);
        if0.sw_clr = 1'b0; if0.sw_pre = 1'b0;
        step();
        check("both2_clr_o", 32'(if0.clr_o), 32'd1);
        check("both2_pre_o", 32'(if0.pre_o), 32'd0);
        step();
        check("both3_clr_o", 32'(if0.clr_o), 32'd0);
        check("both3_pre_o", 32'(if0.pre_o), 32'd0);
        check("both3_ready", 32'(if0.ready), 32'd1);

        // Held sw_clr: ignored mid-pulse, retriggers once IDLE is re-entered.
        if0.sw_clr = 1'b1;
        step();
        check("hc1_clr_o", 32'(if0.clr_o), 32'd1);
        step();
        check("hc2_clr_o", 32'(if0.clr_o), 32'd1);
        check("hc2_ready", 32'(if0.ready), 32'd0);
        step();
        check("hc3_clr_o", 32'(if0.clr_o), 32'd0);
        check("hc3_ready", 32'(if0.ready), 32'd1);
        step();
        check("hc4_clr_o", 32'(if0.clr_o), 32'd1);
        check("hc4_ready", 32'(if0.ready), 32'd0);
        if0.sw_clr = 1'b0;
        step();
        check("hc5_clr_o", 32'(if0.clr_o), 32'd1);
        step();
        check("hc6_clr_o", 32'(if0.clr_o), 32'd0);
        check("hc6_ready", 32'(if0.ready), 32'd1);

        // Asynchronous reset between edges while en_o is high.
        if0.en_req = 1'b1;
        step();
        check("ar_pre_en_o", 32'(if0.en_o), 32'd1);
        #2 clr = 1'b0;
        #1;
        check("ar_clr_o", 32'(if0.clr_o), 32'd1);
        check("ar_en_o",  32'(if0.en_o),  32'd0);
        check("ar_ready", 32'(if0.ready), 32'd0);

        // sw_clr held through reset/hold is ignored until IDLE.
        step();
        if0.sw_clr = 1'b1;
        clr = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("hold_clr_o_e%0d", k), 32'(if0.clr_o), 32'd1);
            check($sformatf("hold_en_o_e%0d", k),  32'(if0.en_o),  32'd0);
        end
        step();
        check("hold_idle_clr_o", 32'(if0.clr_o), 32'd0);
        check("hold_idle_ready", 32'(if0.ready), 32'd1);
        check("hold_idle_en_o",  32'(if0.en_o),  32'd1);
        step();
        check("hold_retrig_clr_o", 32'(if0.clr_o), 32'd1);
        check("hold_retrig_en_o",  32'(if0.en_o),  32'd0);
        if0.sw_clr = 1'b0;
        if0.en_req = 1'b0;

        // HOLD_CYCLES=0 build: ready on the 3rd edge after release.
        clr0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("h0_ready_e%0d", k), 32'(if1.ready), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("h0_clr_o_e%0d", k), 32'(if1.clr_o), (k == 3) ? 32'd0 : 32'd1);
        end

        // Reset mid preset pulse aborts immediately.
        if1.sw_pre = 1'b1;
        step();
        check("h0_pp_pre_o", 32'(if1.pre_o), 32'd1);
        if1.sw_pre = 1'b0;
        #3 clr0 = 1'b0;
        #1;
        check("h0_ab_pre_o", 32'(if1.pre_o), 32'd0);
        check("h0_ab_clr_o", 32'(if1.clr_o), 32'd1);
        check("h0_ab_ready", 32'(if1.ready), 32'd0);
        #2 clr0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("h0_rr_ready_e%0d", k), 32'(if1.ready), (k == 3) ? 32'd1 : 32'd0);
            check($sformatf("h0_rr_pre_o_e%0d", k), 32'(if1.pre_o), 32'd0);
        end

        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
